gps_iq_unload: RTL and testbench
================================

GPS_IQ_UNLOAD -- requirements
Module: gps_iq_unload

Interface
REQ-001 Parameter IB, default GPS_INTEG_BITS (18): width of one serialized I/Q accumulator field.
REQ-002 Parameter CHB, default 4: channel-select width, supporting up to 16 correlator channels.
REQ-003 Parameter DEPTH, default 16: output FIFO depth in words; SHALL be a power of two and at least NF.
REQ-004 clk  in  1  system clock; reset rst, synchronous, active-high.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle pulse requesting an unload of channel chan.
REQ-007 chan  in  CHB  channel index, sampled only on an accepted start.
REQ-008 sel  out  CHB  registered channel select that drives the external sout mux.
REQ-009 shift  out  1  shift strobe to the selected correlator's serial I/Q register.
REQ-010 sin  in  1  muxed sout bit (MSB-first) from the selected channel.
REQ-011 busy  out  1  high from the cycle after an accepted start until done.
REQ-012 done  out  1  one-cycle pulse when the last field has been pushed.
REQ-013 rd  in  1  pop request for the FIFO head.
REQ-014 dout  out  32  FIFO head (first-word-fall-through), with the field in bits [IB-1:0] and zeros above.
REQ-015 empty  out  1  FIFO empty flag.
REQ-016 level  out  log2(DEPTH)+1  FIFO occupancy.
REQ-017 err  out  1  sticky flag marking a rejected start.

Function
REQ-018 Field count NF SHALL be 6 (ip,qp,ie,qe,il,ql); with E1B enabled (REQ-031) NF SHALL be 12, adding ip2..ql2.
REQ-019 A start SHALL be accepted only in IDLE with DEPTH-level >= NF; any other start SHALL be dropped and SHALL set err.
REQ-020 The FSM SHALL have three states, IDLE, SETTLE and SHIFT, with these transitions: IDLE->SETTLE on an accepted start; SETTLE->SHIFT after exactly 1 cycle; SHIFT->IDLE after NF*IB shift cycles.
REQ-021 On an accepted start at cycle 0, sel SHALL update to chan at cycle 1 and SETTLE SHALL occupy cycle 1.
REQ-022 In SHIFT (cycles 2 .. 1+NF*IB), each cycle SHALL capture sin into the field shift register LSB-end and assert shift in the same cycle.
REQ-023 After every IB captured bits the completed field SHALL be pushed to the FIFO on the following cycle, in serial order (field 0 = ip).
REQ-024 done SHALL pulse at cycle 2+NF*IB, and busy SHALL fall in the same cycle.
REQ-025 shift SHALL be 0 outside SHIFT; sel SHALL hold its value in IDLE.
REQ-026 A rd while empty SHALL be ignored; a simultaneous push and pop SHALL both take effect, leaving level unchanged.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH, and level SHALL never exceed DEPTH; REQ-019 guarantees no overflow.
REQ-028 err SHALL be cleared only by reset.

Reset
REQ-029 While rst is high: the FSM SHALL go to IDLE; sel, shift, busy, done and err SHALL be 0; the FIFO SHALL be emptied (level 0, empty 1); the bit and field counters SHALL be 0.
REQ-030 A reset during SHIFT SHALL abort the unload immediately with no further push and no done pulse.

Configuration
REQ-031 Macro GPS_IQ_UNLOAD_E1B_EN: defined gives NF=12 (GPS+Galileo E1B); undefined gives NF=6, with no second-set logic and a narrower field counter.

Structure
REQ-032 The shared package SHALL hold GPS_INTEG_BITS, the NF constants (6/12), and the FSM state enum.
REQ-033 The FIFO SHALL be the sub-module gps_iq_fifo: synchronous, first-word-fall-through, parameterised by width and depth.

Verification
REQ-034 The bench SHALL cover IB=18, NF=6, chan=3: a start at cycle 0 SHALL give sel=3 at cycle 1, shift high for cycles 2..109 (108 cycles), done at cycle 110, level=6, and words in serial order matching a driven pattern (e.g. 0x2AAAA, 0x15555, ...).
REQ-035 The bench SHALL cover a start while busy: the start SHALL be dropped, err=1, and the current unload SHALL complete unchanged.
REQ-036 The bench SHALL cover a FIFO at level 11 (DEPTH 16, NF 6): the start SHALL be rejected with err=1; after 1 rd (level 10) the start SHALL be accepted.
REQ-037 The bench SHALL cover rd asserted every cycle during an unload: level SHALL never exceed 1, and all 6 words SHALL be read in order.
REQ-038 The bench SHALL cover rst asserted at cycle 50 of SHIFT: the next cycle SHALL show shift=0, level=0, busy=0, and no done pulse.
REQ-039 The bench SHALL cover the GPS_IQ_UNLOAD_E1B_EN build: one unload SHALL produce 216 shift cycles, done at cycle 218, and 12 words.

Source files
------------

// File: rtl/gps_iq_unload_pkg.sv
// Shared constants and FSM state type for the GPS correlator I/Q unload path.
package gps_iq_unload_pkg;

    localparam int unsigned GPS_INTEG_BITS = 18;
    localparam int unsigned GPS_NF_BASE    = 6;
    localparam int unsigned GPS_NF_E1B     = 12;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StShift
    } gps_iq_state_e;

endpackage

// File: rtl/gps_iq_fifo.sv
// Synchronous first-word-fall-through FIFO holding unloaded I/Q accumulator fields.
module gps_iq_fifo #(
    parameter int unsigned W     = 18,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [W-1:0]             wdata,
    input  logic                     rd,
    output logic [W-1:0]             rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          pop;

    // Writes never overflow: the unload controller only starts with room for a full set.
    always_comb begin
        pop     = rd && (level_q != '0);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (wr) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        level_d = level_q + (AW + 1)'(wr) - (AW + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/gps_iq_unload.sv
// Serial unload of one correlator channel's I/Q accumulators into a FIFO.
// Define GPS_IQ_UNLOAD_E1B_EN to add the second (Galileo E1B) field set.
module gps_iq_unload
    import gps_iq_unload_pkg::*;
#(
    parameter int unsigned IB    = GPS_INTEG_BITS,
    parameter int unsigned CHB   = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CHB-1:0]         chan,
    output logic [CHB-1:0]         sel,
    output logic                   shift,
    input  logic                   sin,
    output logic                   busy,
    output logic                   done,
    input  logic                   rd,
    output logic [31:0]            dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err
);

`ifdef GPS_IQ_UNLOAD_E1B_EN
    localparam int unsigned NF = GPS_NF_E1B;
`else
    localparam int unsigned NF = GPS_NF_BASE;
`endif
    localparam int unsigned BW = $clog2(IB);
    localparam int unsigned FW = $clog2(NF);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    gps_iq_state_e  state_q, state_d;
    logic [CHB-1:0] sel_q, sel_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [FW-1:0]  fld_q, fld_d;
    logic [IB-1:0]  sr_q, sr_d;
    logic           shift_q, shift_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           push_q, push_d;
    logic           err_q, err_d;
    logic           accept;
    logic [LW:0]    used;
    logic [IB-1:0]  fifo_rdata;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        bit_d   = bit_q;
        fld_d   = fld_q;
        sr_d    = sr_q;
        err_d   = err_q;
        push_d  = 1'b0;
        done_d  = 1'b0;
        // Count the push still in flight so a start right after done cannot overfill.
        used    = {1'b0, level} + (LW + 1)'(push_q);
        accept  = start && (state_q == StIdle) && (used <= (LW + 1)'(DEPTH - NF));
        if (start && !accept) begin
            err_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSettle;
                    sel_d   = chan;
                    bit_d   = '0;
                    fld_d   = '0;
                end
            end
            StSettle: state_d = StShift;
            StShift: begin
                sr_d = {sr_q[IB-2:0], sin};
                if (bit_q == BW'(IB - 1)) begin
                    bit_d  = '0;
                    push_d = 1'b1;
                    if (fld_q == FW'(NF - 1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        fld_d = fld_q + FW'(1);
                    end
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        shift_d = (state_d == StShift);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= '0;
            bit_q   <= '0;
            fld_q   <= '0;
            sr_q    <= '0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            push_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            bit_q   <= bit_d;
            fld_q   <= fld_d;
            sr_q    <= sr_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            push_q  <= push_d;
            err_q   <= err_d;
        end
    end

    gps_iq_fifo #(
        .W     (IB),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (push_q),
        .wdata (sr_q),
        .rd    (rd),
        .rdata (fifo_rdata),
        .empty (empty),
        .level (level)
    );

    assign sel   = sel_q;
    assign shift = shift_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign dout  = {{(32 - IB){1'b0}}, fifo_rdata};

endmodule

// File: tb/tb_gps_iq_unload.sv
// Scoreboard bench for gps_iq_unload; expected FIFO words queued at each accepted start.
module tb_gps_iq_unload;

    localparam int unsigned IB    = 18;
    localparam int unsigned CHB   = 4;
    localparam int unsigned DEPTH = 16;
`ifdef GPS_IQ_UNLOAD_E1B_EN
    localparam int NF = 12;
`else
    localparam int NF = 6;
`endif
    localparam int NSH = NF * IB;

    logic           clk = 1'b0;
    logic           rst, start, sin, rd;
    logic [CHB-1:0] chan, sel;
    logic           shift, busy, done, empty, err;
    logic [31:0]    dout;
    logic [4:0]     level;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];
    logic        bit_q [$];
    logic [17:0] pat [12] = '{18'h2AAAA, 18'h15555, 18'h3FFFF, 18'h00000, 18'h12345, 18'h3C0F0,
                              18'h0F0F0, 18'h2468A, 18'h1357B, 18'h3FFFE, 18'h00001, 18'h20000};

    gps_iq_unload #(
        .IB    (IB),
        .CHB   (CHB),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .chan  (chan),
        .sel   (sel),
        .shift (shift),
        .sin   (sin),
        .busy  (busy),
        .done  (done),
        .rd    (rd),
        .dout  (dout),
        .empty (empty),
        .level (level),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    // Serial source: the selected channel presents its next bit for each shift strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (shift === 1'b1) begin
                if (bit_q.size() > 0) sin = bit_q.pop_front();
                else sin = 1'b0;
            end
        end
    end

    // Monitor: every real pop is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rd === 1'b1 && empty === 1'b0 && rst === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got 0x%0h, expected no word", dout);
                end else begin
                    check("fifo_word", dout, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic load_fields(input int base, input bit with_exp);
        logic [17:0] w;
        for (int k = 0; k < NF; k++) begin
            w = pat[(base + k) % 12];
            if (with_exp) exp_q.push_back(32'(w));
            for (int b = IB - 1; b >= 0; b--) bit_q.push_back(w[b]);
        end
    endtask

    task automatic run_unload(input logic [CHB-1:0] ch, input int base, input int inj_at,
                              output int max_lvl);
        int first_sh, last_sh, n_sh, done_at, n_done;
        first_sh = -1; last_sh = -1; n_sh = 0; done_at = -1; n_done = 0; max_lvl = 0;
        load_fields(base, 1'b1);
        start = 1'b1;
        chan  = ch;
        step();
        start = 1'b0;
        chan  = ~ch;
        check("sel_c1", 32'(sel), 32'(ch));
        check("busy_c1", 32'(busy), 1);
        check("shift_c1", 32'(shift), 0);
        for (int c = 1; c <= NSH + 4; c++) begin
            if (shift) begin
                if (first_sh < 0) first_sh = c;
                last_sh = c;
                n_sh++;
            end
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = c;
                check("busy_at_done", 32'(busy), 0);
            end
            if (int'(level) > max_lvl) max_lvl = int'(level);
            start = (c == inj_at);
            if (c == inj_at) chan = 4'd7;
            step();
        end
        start = 1'b0;
        check("first_shift_cycle", first_sh, 2);
        check("last_shift_cycle", last_sh, NSH + 1);
        check("shift_count", n_sh, NSH);
        check("done_cycle", done_at, NSH + 2);
        check("done_pulses", n_done, 1);
        check("sel_hold", 32'(sel), 32'(ch));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (!empty && g < 2 * DEPTH) begin
            pop_one();
            g++;
        end
        check("drain_empty", 32'(empty), 1);
        check("drain_scoreboard", exp_q.size(), 0);
    endtask

    initial begin
        int ml, g, n_done, n_sh;
        rst = 1'b1; start = 1'b0; chan = '0; rd = 1'b0; sin = 1'b0;
        repeat (3) step();
        check("rst_sel", 32'(sel), 0);
        check("rst_shift", 32'(shift), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_level", 32'(level), 0);
        rst = 1'b0;
        step();

        // Reads on an empty FIFO are ignored.
        rd = 1'b1;
        step();
        step();
        rd = 1'b0;
        check("rd_empty_level", 32'(level), 0);
        check("rd_empty_flag", 32'(empty), 1);

        // Basic unload of channel 3.
        run_unload(4'd3, 0, -1, ml);
        check("basic_level", 32'(level), NF);
        check("basic_err", 32'(err), 0);
        drain();

        // Start while busy is dropped and flagged; current unload unaffected.
        run_unload(4'd5, 1, 20, ml);
        check("busy_start_err", 32'(err), 1);
        check("busy_start_level", 32'(level), NF);
        drain();
        check("err_sticky", 32'(err), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("err_cleared_by_rst", 32'(err), 0);

        // Room check: one word short rejects, one pop later accepts.
        g = 0;
        while (int'(level) + NF <= DEPTH && g < 4) begin
            run_unload(4'd1, 2 + g, -1, ml);
            g++;
        end
        g = 0;
        while (int'(level) > DEPTH - NF + 1 && g < 32) begin
            pop_one();
            g++;
        end
        check("room_level_pre", 32'(level), DEPTH - NF + 1);
        start = 1'b1;
        chan  = 4'd9;
        step();
        start = 1'b0;
        check("room_reject_err", 32'(err), 1);
        check("room_reject_busy", 32'(busy), 0);
        step();
        check("room_reject_idle", 32'(busy), 0);
        pop_one();
        check("room_level_ok", 32'(level), DEPTH - NF);
        run_unload(4'd9, 4, -1, ml);
        check("full_level", 32'(level), DEPTH);
        drain();

        // Continuous reads during an unload.
        rd = 1'b1;
        run_unload(4'd2, 6, -1, ml);
        rd = 1'b0;
        check("rd_every_cycle_max_level", ml, 1);
        check("rd_every_cycle_empty", 32'(empty), 1);
        check("rd_every_cycle_sb", exp_q.size(), 0);

        // Reset in the 50th SHIFT cycle aborts the unload.
        load_fields(8, 1'b0);
        start = 1'b1;
        chan  = 4'd1;
        step();
        start = 1'b0;
        repeat (50) step();
        check("abort_pre_level", 32'(level), 2);
        check("abort_pre_shift", 32'(shift), 1);
        rst = 1'b1;
        step();
        check("abort_shift", 32'(shift), 0);
        check("abort_level", 32'(level), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        rst = 1'b0;
        bit_q.delete();
        n_done = 0;
        n_sh = 0;
        for (int c = 0; c < NSH + 10; c++) begin
            if (done) n_done++;
            if (shift) n_sh++;
            step();
        end
        check("abort_no_done", n_done, 0);
        check("abort_no_shift", n_sh, 0);
        check("abort_no_push", 32'(level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
